// File: rtl/fp16_dot_accum_if.sv
// Bundle of the element stream, FMA issue/return and result channels of fp16_dot_accum.
// slave is the sequencer's view; master is the surrounding system (source, FMA and sink).
interface fp16_dot_accum_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_a;
   logic [15:0] s_b;
   logic        s_last;

   logic        fma_in_valid;
   logic [15:0] fma_a;
   logic [15:0] fma_b;
   logic [15:0] fma_c;
   logic        fma_out_valid;
   logic [15:0] fma_out;

   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;

   modport slave (
      input  s_valid, s_a, s_b, s_last, fma_out_valid, fma_out, m_ready,
      output s_ready, fma_in_valid, fma_a, fma_b, fma_c, m_valid, m_data
   );

   modport master (
      output s_valid, s_a, s_b, s_last, fma_out_valid, fma_out, m_ready,
      input  s_ready, fma_in_valid, fma_a, fma_b, fma_c, m_valid, m_data
   );
endinterface

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 dot-product sequencer: LAT interleaved partial sums hide the external FMA
// latency, then a fixed-order pairwise tree through the same FMA reduces them to one result.
module fp16_dot_accum #(
   parameter int LAT = 4   // FMA latency and number of partial slots: 2, 4 or 8
) (
   input  logic             clk,
   input  logic             rst,
   fp16_dot_accum_if.slave  io
);
   localparam int          PW      = $clog2(LAT);
   localparam logic [15:0] FP_ONE  = 16'h3C00;

   typedef enum logic [1:0] {ACCUM, DRAIN, REDUCE, OUT} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   p_q;
   logic [1:0]      round_q, round_d;
   logic [PW-1:0]   idx_q, idx_d;
   logic [15:0]     m_data_q, m_data_d;
   logic [15:0]     partial_q [LAT];
   logic [LAT-1:0]  tag_v_q;
   logic [PW-1:0]   tag_dst_q [LAT];

   logic            issue;
   logic            s_rdy;
   logic            clear_parts;
   logic [15:0]     iss_a, iss_b, iss_c;
   logic [PW-1:0]   iss_dst;

   logic            ret_en;
   logic [PW-1:0]   ret_dst;
   logic            in_flight;
   logic [PW-1:0]   n_ops;
   logic            last_round;
   logic [PW-1:0]   lo_idx, hi_idx;
   logic [15:0]     part_fwd [LAT];

   // The oldest tag stage lines up with the FMA result; results without a live tag are stale.
   assign ret_en    = io.fma_out_valid & tag_v_q[LAT-1];
   assign ret_dst   = tag_dst_q[LAT-1];
   assign in_flight = |tag_v_q[LAT-2:0];

   assign n_ops      = PW'(LAT >> (round_q + 2'd1));
   assign last_round = (n_ops == PW'(1));
   assign lo_idx     = PW'({idx_q, 1'b0});
   assign hi_idx     = lo_idx | PW'(1);

   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_fwd
         assign part_fwd[gi] = (ret_en && ret_dst == PW'(gi)) ? io.fma_out : partial_q[gi];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      idx_d       = idx_q;
      m_data_d    = m_data_q;
      issue       = 1'b0;
      s_rdy       = 1'b0;
      clear_parts = 1'b0;
      iss_a       = '0;
      iss_b       = '0;
      iss_c       = '0;
      iss_dst     = p_q;
      case (state_q)
         ACCUM: begin
            s_rdy = 1'b1;
            if (io.s_valid) begin
               // A slot's previous result returns exactly when the pointer comes back to it.
               issue   = 1'b1;
               iss_a   = io.s_a;
               iss_b   = io.s_b;
               iss_c   = part_fwd[p_q];
               iss_dst = p_q;
               if (io.s_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!in_flight) begin
               state_d = REDUCE;
               round_d = '0;
               idx_d   = '0;
            end
         end
         REDUCE: begin
            if (idx_q != n_ops) begin
               issue   = 1'b1;
               iss_a   = partial_q[lo_idx];
               iss_b   = FP_ONE;
               iss_c   = partial_q[hi_idx];
               iss_dst = idx_q;
               idx_d   = idx_q + PW'(1);
            end else if (!in_flight) begin
               if (last_round) begin
                  state_d  = OUT;
                  m_data_d = part_fwd[0];
               end else begin
                  round_d = round_q + 2'd1;
                  idx_d   = '0;
               end
            end
         end
         OUT: begin
            if (io.m_ready) begin
               clear_parts = 1'b1;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ACCUM;
         p_q      <= '0;
         round_q  <= '0;
         idx_q    <= '0;
         m_data_q <= '0;
         tag_v_q  <= '0;
         for (int k = 0; k < LAT; k++) begin
            partial_q[k] <= '0;
            tag_dst_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         p_q      <= p_q + PW'(1);
         round_q  <= round_d;
         idx_q    <= idx_d;
         m_data_q <= m_data_d;
         tag_v_q  <= {tag_v_q[LAT-2:0], issue};
         tag_dst_q[0] <= iss_dst;
         for (int k = 1; k < LAT; k++) tag_dst_q[k] <= tag_dst_q[k-1];
         for (int k = 0; k < LAT; k++) begin
            if (clear_parts)                         partial_q[k] <= '0;
            else if (ret_en && ret_dst == PW'(k))    partial_q[k] <= io.fma_out;
         end
      end
   end

   // Outputs are forced to their idle values while reset is held.
   assign io.s_ready      = s_rdy & ~rst;
   assign io.fma_in_valid = issue & ~rst;
   assign io.fma_a        = (issue && !rst) ? iss_a : 16'h0000;
   assign io.fma_b        = (issue && !rst) ? iss_b : 16'h0000;
   assign io.fma_c        = (issue && !rst) ? iss_c : 16'h0000;
   assign io.m_valid      = (state_q == OUT) & ~rst;
   assign io.m_data       = rst ? 16'h0000 : m_data_q;
endmodule
